mem_wb_queue: RTL and testbench
===============================

MEM_WB_QUEUE -- requirements
Module: mem_wb_queue

Interface
REQ-001 Parameter XLEN, 32, datapath width of pc/res fields.
REQ-002 Parameter DEPTH, 2, entry count (legal 1..8, need not be power of two).
REQ-003 Parameter NREGS, 32, architectural register count; RW = $clog2(NREGS).
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  MEM stage presents an entry.
REQ-007 in_ready  out  1  queue accepts the entry this cycle.
REQ-008 in_pc, in_res  in  XLEN each  entry pc and result.
REQ-009 in_rd  in  RW  destination register; in_w_rd  in  1  register write enable.
REQ-010 in_cmp_res  in  2  compare result; in_w_cr  in  1  compare-register write enable.
REQ-011 in_trap  in  3  {udf, eret, scall}.
REQ-012 flush  in  1  discard all queued entries.
REQ-013 out_valid  out  1 / out_ready  in  1  writeback-side handshake.
REQ-014 out_pc, out_res, out_rd, out_w_rd, out_cmp_res, out_w_cr, out_trap  out  widths as inputs  head entry.
REQ-015 fwd_rs  in  RW  forwarding lookup register; fwd_hit  out  1; fwd_data  out  XLEN.
REQ-016 count  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-017 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-018 Circular buffer: write pointer advances on push, read pointer on pop, each wrapping DEPTH-1 -> 0.
REQ-019 Latency: a pushed entry appears at out_* with out_valid=1 the cycle after push; no combinational in->out path.
REQ-020 out_valid = (count != 0); out_* fields SHALL be 0 when out_valid=0, else the head entry.
REQ-021 in_ready = (count < DEPTH) && !trap_pend && !flush, combinational from state and flush only.
REQ-022 Simultaneous push and pop with 0<count<DEPTH keeps count unchanged, both pointers advance.
REQ-023 Full (count==DEPTH): in_ready=0; a pop that cycle does not enable a push (no same-cycle refill).
REQ-024 trap_pend sets on push of any entry with in_trap != 0 and clears on pop of that entry; traps therefore serialise, no entry follows a trap until it retires.
REQ-025 flush (synchronous): next cycle count=0, both pointers 0, trap_pend=0; push and pop in the flush cycle are discarded/ignored.
REQ-026 fwd_hit=1 iff some occupied entry has w_rd=1, rd==fwd_rs and rd != 0; combinational.
REQ-027 On multiple matches fwd_data SHALL be res of the youngest (most recently pushed) match; fwd_data=0 when fwd_hit=0.
REQ-028 Forwarding reflects registered state only; an entry pushed this cycle is not visible until the next cycle.
REQ-029 count equals pushes minus pops since last reset/flush, never exceeds DEPTH, never underflows.

Reset
REQ-030 rst_n low SHALL immediately clear pointers, count, trap_pend and entry valid state regardless of clk.
REQ-031 During and after reset: out_valid=0, all out_* =0, fwd_hit=0, fwd_data=0, count=0, in_ready=1.
REQ-032 Reset asserted mid-operation discards all entries; first push after release behaves as on an empty queue.

Verification
REQ-033 DEPTH=2: push A (res=0x11, rd=3), push B (res=0x22, rd=3), out_ready=0 -> count=2, in_ready=0, fwd_rs=3 gives fwd_hit=1, fwd_data=0x22.
REQ-034 From full, out_ready=1 with in_valid=1 -> A popped, no push that cycle, count=1; next cycle push accepted, pointer wrap verified with 6 push/pop pairs in order.
REQ-035 Push entry in_trap=3'b001 then in_valid=1 continuously -> in_ready=0 until trap entry popped, then 1 next cycle.
REQ-036 count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, fwd_hit=0; flushed-cycle entry never appears.
REQ-037 Push rd=0 w_rd=1 res=0xFF, fwd_rs=0 -> fwd_hit=0; push rd=5 w_rd=0, fwd_rs=5 -> fwd_hit=0.
REQ-038 Assert rst_n=0 between clock edges with count=2 -> outputs clear before next edge, in_ready=1.

Source files
------------

// File: rtl/mem_wb_queue.sv
// ---------------------------------------------------------------------------
// mem_wb_queue
// Small circular queue between the MEM and WB pipeline stages. Each entry
// holds pc, result, destination register, compare result, write enables and
// trap flags. The queue also offers register forwarding: any occupied entry
// that writes a nonzero register can supply its result to a lookup, with the
// youngest matching entry winning.
//
// Parameters
//   XLEN  : width of pc/res fields
//   DEPTH : number of entries (1..8, need not be a power of two)
//   NREGS : architectural register count, RW = $clog2(NREGS)
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_valid/ready   : MEM-side handshake
//   in_pc .. in_trap : entry fields written on push
//   flush            : synchronous discard of all entries
//   out_valid/ready  : WB-side handshake
//   out_pc .. out_trap : head entry fields, zero when the queue is empty
//   fwd_rs           : forwarding lookup register
//   fwd_hit/fwd_data : forwarding result (combinational, registered state only)
//   count            : number of occupied entries
// ---------------------------------------------------------------------------
module mem_wb_queue #(
    parameter int  XLEN  = 32,
    parameter int  DEPTH = 2,
    parameter int  NREGS = 32,
    localparam int RW    = $clog2(NREGS),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_res,
    input  logic [RW-1:0]   in_rd,
    input  logic            in_w_rd,
    input  logic [1:0]      in_cmp_res,
    input  logic            in_w_cr,
    input  logic [2:0]      in_trap,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_res,
    output logic [RW-1:0]   out_rd,
    output logic            out_w_rd,
    output logic [1:0]      out_cmp_res,
    output logic            out_w_cr,
    output logic [2:0]      out_trap,
    input  logic [RW-1:0]   fwd_rs,
    output logic            fwd_hit,
    output logic [XLEN-1:0] fwd_data,
    output logic [CW-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry storage
    logic [XLEN-1:0] pc_q      [DEPTH];
    logic [XLEN-1:0] res_q     [DEPTH];
    logic [RW-1:0]   rd_q      [DEPTH];
    logic            w_rd_q    [DEPTH];
    logic [1:0]      cmp_res_q [DEPTH];
    logic            w_cr_q    [DEPTH];
    logic [2:0]      trap_q    [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          trap_pend;
    logic          push;
    logic          pop;

    // Pointers wrap at DEPTH-1, which matters when DEPTH is not a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (int'(p) == DEPTH - 1)
            return '0;
        else
            return p + 1'b1;
    endfunction

    // A full queue refuses pushes even while popping, and an outstanding trap
    // blocks everything behind it so traps retire one at a time.
    assign in_ready  = (int'(count_q) < DEPTH) && !trap_pend && !flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_q;

    // Control state: pointers, occupancy, per-entry valid bits, trap blocking.
    // At most one trap entry can be queued, so popping any trap entry clears
    // the blocking flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            trap_pend <= 1'b0;
            valid_q   <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            trap_pend <= 1'b0;
            valid_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr          <= next_ptr(wr_ptr);
                valid_q[wr_ptr] <= 1'b1;
                if (in_trap != 3'b000)
                    trap_pend <= 1'b1;
            end
            if (pop) begin
                rd_ptr          <= next_ptr(rd_ptr);
                valid_q[rd_ptr] <= 1'b0;
                if (trap_q[rd_ptr] != 3'b000)
                    trap_pend <= 1'b0;
            end
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
        end
    end

    // Payload needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]      <= in_pc;
            res_q[wr_ptr]     <= in_res;
            rd_q[wr_ptr]      <= in_rd;
            w_rd_q[wr_ptr]    <= in_w_rd;
            cmp_res_q[wr_ptr] <= in_cmp_res;
            w_cr_q[wr_ptr]    <= in_w_cr;
            trap_q[wr_ptr]    <= in_trap;
        end
    end

    // Head entry presentation, forced to zero when empty.
    always_comb begin
        out_pc      = '0;
        out_res     = '0;
        out_rd      = '0;
        out_w_rd    = 1'b0;
        out_cmp_res = '0;
        out_w_cr    = 1'b0;
        out_trap    = '0;
        if (out_valid) begin
            out_pc      = pc_q[rd_ptr];
            out_res     = res_q[rd_ptr];
            out_rd      = rd_q[rd_ptr];
            out_w_rd    = w_rd_q[rd_ptr];
            out_cmp_res = cmp_res_q[rd_ptr];
            out_w_cr    = w_cr_q[rd_ptr];
            out_trap    = trap_q[rd_ptr];
        end
    end

    // Forwarding walks entries from oldest to youngest so the last match
    // found is the most recently pushed one. Register 0 never forwards.
    always_comb begin
        int          idx;
        logic [PW-1:0] sel;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = 0;
        sel      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = int'(rd_ptr) + k;
            if (idx >= DEPTH)
                idx = idx - DEPTH;
            sel = PW'(idx);
            if ((k < int'(count_q)) && valid_q[sel] && w_rd_q[sel] &&
                (rd_q[sel] == fwd_rs) && (fwd_rs != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = res_q[sel];
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_queue
// Self-checking bench for mem_wb_queue (DEPTH=2). A queue-of-entries model
// predicts head fields, occupancy, readiness and forwarding every cycle.
// Directed scenarios cover fill/drain, wrap, trap blocking, flush, register-0
// forwarding and asynchronous reset; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_mem_wb_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int NREGS = 32;
    localparam int RW    = 5;
    localparam int CW    = 2;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_res;
    logic [RW-1:0]   in_rd;
    logic            in_w_rd;
    logic [1:0]      in_cmp_res;
    logic            in_w_cr;
    logic [2:0]      in_trap;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_res;
    logic [RW-1:0]   out_rd;
    logic            out_w_rd;
    logic [1:0]      out_cmp_res;
    logic            out_w_cr;
    logic [2:0]      out_trap;
    logic [RW-1:0]   fwd_rs;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;
    logic [CW-1:0]   count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        w_rd;
        logic [1:0]  cmp;
        logic        w_cr;
        logic [2:0]  trap;
    } entry_t;

    entry_t q[$];
    int     nChecks = 0;
    int     nFails  = 0;

    mem_wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_res(in_res), .in_rd(in_rd), .in_w_rd(in_w_rd),
        .in_cmp_res(in_cmp_res), .in_w_cr(in_w_cr), .in_trap(in_trap),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_res(out_res), .out_rd(out_rd), .out_w_rd(out_w_rd),
        .out_cmp_res(out_cmp_res), .out_w_cr(out_w_cr), .out_trap(out_trap),
        .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic bit trapPending();
        bit tp;
        tp = 1'b0;
        foreach (q[i])
            if (q[i].trap != 3'b000)
                tp = 1'b1;
        return tp;
    endfunction

    // Compare every output against the model's view of the queue.
    task automatic checkAll(input string tag);
        entry_t      h;
        bit          hit;
        logic [31:0] fd;
        bit          expReady;
        h   = '0;
        hit = 1'b0;
        fd  = '0;
        if (q.size() > 0)
            h = q[0];
        foreach (q[i])
            if (q[i].w_rd && (q[i].rd == fwd_rs) && (fwd_rs != 5'd0)) begin
                hit = 1'b1;
                fd  = q[i].res;
            end
        expReady = (q.size() < DEPTH) && !trapPending() && !flush;
        checkOutput({tag, "/in_ready"},  64'(in_ready),    64'(expReady));
        checkOutput({tag, "/out_valid"}, 64'(out_valid),   64'(q.size() > 0));
        checkOutput({tag, "/count"},     64'(count),       64'(q.size()));
        checkOutput({tag, "/out_pc"},    64'(out_pc),      64'(h.pc));
        checkOutput({tag, "/out_res"},   64'(out_res),     64'(h.res));
        checkOutput({tag, "/out_rd"},    64'(out_rd),      64'(h.rd));
        checkOutput({tag, "/out_w_rd"},  64'(out_w_rd),    64'(h.w_rd));
        checkOutput({tag, "/out_cmp"},   64'(out_cmp_res), 64'(h.cmp));
        checkOutput({tag, "/out_w_cr"},  64'(out_w_cr),    64'(h.w_cr));
        checkOutput({tag, "/out_trap"},  64'(out_trap),    64'(h.trap));
        checkOutput({tag, "/fwd_hit"},   64'(fwd_hit),     64'(hit));
        checkOutput({tag, "/fwd_data"},  64'(fwd_data),    64'(fd));
    endtask

    // One clock: check outputs, then advance the model across the edge.
    task automatic cycle(input string tag);
        bit     doPush;
        bit     doPop;
        entry_t e;
        #1;
        checkAll(tag);
        doPush = in_valid && (q.size() < DEPTH) && !trapPending() && !flush;
        doPop  = (q.size() > 0) && out_ready && !flush;
        e.pc   = in_pc;
        e.res  = in_res;
        e.rd   = in_rd;
        e.w_rd = in_w_rd;
        e.cmp  = in_cmp_res;
        e.w_cr = in_w_cr;
        e.trap = in_trap;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (doPop)
                void'(q.pop_front());
            if (doPush)
                q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic setIn(input bit v, input logic [31:0] res, input logic [4:0] rd,
                         input bit wrd, input logic [2:0] trap, input bit ordy,
                         input bit fl, input logic [4:0] frs);
        in_valid   = v;
        in_pc      = $urandom;
        in_res     = res;
        in_rd      = rd;
        in_w_rd    = wrd;
        in_cmp_res = 2'($urandom_range(0, 3));
        in_w_cr    = 1'($urandom_range(0, 1));
        in_trap    = trap;
        out_ready  = ordy;
        flush      = fl;
        fwd_rs     = frs;
    endtask

    task automatic applyStimulus();
        logic [2:0] tr;
        tr = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        setIn($urandom_range(0, 9) < 7, $urandom, 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), tr, $urandom_range(0, 9) < 6,
              $urandom_range(0, 24) == 0, 5'($urandom_range(0, 7)));
        cycle("rand");
    endtask

    initial begin
        rst_n = 1'b0;
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with two writers of r3; youngest must forward.
        setIn(1, 32'h11, 5'd3, 1, 3'b000, 0, 0, 5'd3);
        cycle("fillA");
        setIn(1, 32'h22, 5'd3, 1, 3'b000, 0, 0, 5'd3);
        cycle("fillB");
        setIn(0, 0, 0, 0, 3'b000, 0, 0, 5'd3);
        #1;
        checkOutput("full_count", 64'(count), 64'd2);
        checkOutput("full_ready", 64'(in_ready), 64'd0);
        checkOutput("full_fwd_hit", 64'(fwd_hit), 64'd1);
        checkOutput("full_fwd_data", 64'(fwd_data), 64'h22);
        cycle("full");

        // Pop from full with a push offered: no same-cycle refill.
        setIn(1, 32'h33, 5'd4, 1, 3'b000, 1, 0, 5'd4);
        cycle("popfull");
        #1;
        checkOutput("popfull_count", 64'(count), 64'd1);
        for (int i = 0; i < 6; i++) begin
            setIn(1, 32'h40 + i, 5'd4, 1, 3'b000, 1, 0, 5'd4);
            cycle("wrap");
        end
        for (int i = 0; i < 3; i++) begin
            setIn(0, 0, 0, 0, 3'b000, 1, 0, 0);
            cycle("drain");
        end

        // Trap entry blocks pushes until it retires.
        setIn(1, 32'h55, 5'd6, 1, 3'b001, 0, 0, 5'd6);
        cycle("trap");
        setIn(1, 32'h66, 5'd7, 1, 3'b000, 0, 0, 5'd6);
        #1;
        checkOutput("trap_block", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++)
            cycle("trapwait");
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle("trapret");

        // Flush with a push offered: everything discarded.
        for (int i = 0; i < 4; i++) begin
            setIn(0, 0, 0, 0, 3'b000, 1, 0, 0);
            cycle("predrain");
        end
        setIn(1, 32'h81, 5'd2, 1, 3'b000, 0, 0, 5'd2);
        cycle("fl1");
        setIn(1, 32'h82, 5'd2, 1, 3'b000, 0, 0, 5'd2);
        cycle("fl2");
        setIn(1, 32'h83, 5'd2, 1, 3'b000, 1, 1, 5'd2);
        cycle("flush");
        setIn(0, 0, 0, 0, 3'b000, 0, 0, 5'd2);
        #1;
        checkOutput("flush_count", 64'(count), 64'd0);
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_fwd", 64'(fwd_hit), 64'd0);
        cycle("postflush");

        // Register 0 and non-writing entries never forward.
        setIn(1, 32'hFF, 5'd0, 1, 3'b000, 0, 0, 5'd0);
        cycle("r0");
        setIn(1, 32'h77, 5'd5, 0, 3'b000, 0, 0, 5'd0);
        cycle("nowr");
        setIn(0, 0, 0, 0, 3'b000, 0, 0, 5'd0);
        #1;
        checkOutput("r0_fwd", 64'(fwd_hit), 64'd0);
        fwd_rs = 5'd5;
        #1;
        checkOutput("nowr_fwd", 64'(fwd_hit), 64'd0);

        // Asynchronous reset between edges with two entries queued.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        checkAll("areset");
        checkOutput("areset_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++)
            applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
